// File: rtl/tanh_activation_unit.sv
// Purpose : iterative tanh(x) for a Q2.18 operand: hyperbolic CORDIC on x/2, then 2sc/(c^2+s^2) by restoring division.
// Latency : 38 cycles from the accepting start edge to the result edge; next start accepted one cycle later.
// Backpr. : none; start is a single-cycle pulse sampled only while idle, ignored (not queued) while busy.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - request pulse, sampled only in IDLE
//   input_angle       - signed Q2.18 operand, captured on the accepting edge
//   busy              - high from the accepting edge until the result edge
//   tanh_value        - signed Q2.18 result, updated only on the edge where busy falls
module tanh_activation_unit #(
    parameter int DATA_W = 20,
    parameter int FRAC_W = 18,
    parameter int ITER   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] input_angle,
    output logic                     busy,
    output logic signed [DATA_W-1:0] tanh_value
);

    // CORDIC datapath: 26-bit signed, 22 fractional bits.
    localparam int CW = 26;
    localparam int CF = 22;
    // Full-precision products of two non-negative 25-bit values plus headroom.
    localparam int PW = 2 * CW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ROTATE  = 3'd1;
    localparam logic [2:0] S_PRODUCT = 3'd2;
    localparam logic [2:0] S_DIVIDE  = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // ITER shift indices plus the two repeated ones (4 and 13).
    localparam logic [4:0] ROT_LAST = 5'(ITER + 1);
    localparam logic [4:0] DIV_LAST = 5'(FRAC_W - 1);

    logic [2:0]          state;
    logic [4:0]          cnt;
    logic                sign_r;
    logic signed [CW-1:0] cx, cy, cz;
    logic [PW-1:0]       rem;
    logic [PW-1:0]       den;
    logic [FRAC_W-1:0]   q;

    // Iteration counter -> shift index: 1,2,3,4,4,5,...,13,13,14,15,16.
    function automatic logic [4:0] shift_of(input logic [4:0] k);
        if (k <= 5'd3)
            return k + 5'd1;
        else if (k <= 5'd13)
            return k;
        else
            return k - 5'd1;
    endfunction

    // atanh(2^-i), Q.22, truncated.
    function automatic logic signed [CW-1:0] atanh_rom(input logic [4:0] i);
        case (i)
            5'd1:    return 26'sd2303956;
            5'd2:    return 26'sd1071278;
            5'd3:    return 26'sd527044;
            5'd4:    return 26'sd262486;
            5'd5:    return 26'sd131114;
            5'd6:    return 26'sd65541;
            5'd7:    return 26'sd32768;
            5'd8:    return 26'sd16384;
            5'd9:    return 26'sd8192;
            5'd10:   return 26'sd4096;
            5'd11:   return 26'sd2048;
            5'd12:   return 26'sd1024;
            5'd13:   return 26'sd512;
            5'd14:   return 26'sd256;
            5'd15:   return 26'sd128;
            5'd16:   return 26'sd64;
            default: return 26'sd0;
        endcase
    endfunction

    // Operand magnitude; -2.0 maps to 0x80000, which is still representable unsigned.
    logic [DATA_W-1:0]    in_mag;
    logic signed [CW-1:0] z_init;

    always_comb begin
        in_mag = input_angle[DATA_W-1] ? -input_angle : input_angle;
        // Q.18 magnitude -> Q.22, halved: rotate by x/2 so cosh/sinh stay small.
        z_init = signed'({{(CW-DATA_W){1'b0}}, in_mag} << (CF - FRAC_W - 1));
    end

    // One CORDIC micro-rotation on the pre-update values.
    logic [4:0]           sh;
    logic signed [CW-1:0] x_shr, y_shr, ang;
    logic signed [CW-1:0] x_nx, y_nx, z_nx;

    always_comb begin
        sh    = shift_of(cnt);
        x_shr = cx >>> sh;
        y_shr = cy >>> sh;
        ang   = atanh_rom(sh);
        if (!cz[CW-1]) begin
            x_nx = cx + y_shr;
            y_nx = cy + x_shr;
            z_nx = cz - ang;
        end else begin
            x_nx = cx - y_shr;
            y_nx = cy - x_shr;
            z_nx = cz + ang;
        end
    end

    // c = K*cosh(x/2), s = K*sinh(x/2). For a zero operand the final y can
    // settle a few LSB below zero; clamp so the products stay unsigned.
    logic [PW-1:0] c_w, s_w;
    logic [PW-1:0] num_p, den_p;

    always_comb begin
        c_w   = cx[CW-1] ? '0 : {{(PW-CW+1){1'b0}}, cx[CW-2:0]};
        s_w   = cy[CW-1] ? '0 : {{(PW-CW+1){1'b0}}, cy[CW-2:0]};
        num_p = (s_w * c_w) << 1;
        den_p = c_w * c_w + s_w * s_w;
    end

    // Restoring division step; rem < den holds, so the doubled remainder fits.
    logic [PW-1:0] rem_sh;
    logic          rem_ge;

    always_comb begin
        rem_sh = {rem[PW-2:0], 1'b0};
        rem_ge = (rem_sh >= den);
    end

    logic [DATA_W-1:0] q_ext;
    assign q_ext = {{(DATA_W-FRAC_W){1'b0}}, q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sign_r     <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            cz         <= '0;
            rem        <= '0;
            den        <= '0;
            q          <= '0;
            busy       <= 1'b0;
            tanh_value <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_r <= input_angle[DATA_W-1];
                        cx     <= CW'(1) <<< CF;
                        cy     <= '0;
                        cz     <= z_init;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    cx <= x_nx;
                    cy <= y_nx;
                    cz <= z_nx;
                    if (cnt == ROT_LAST) begin
                        cnt   <= '0;
                        state <= S_PRODUCT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_PRODUCT: begin
                    // CORDIC gain K^2 appears in both terms and cancels.
                    rem   <= num_p;
                    den   <= den_p;
                    q     <= '0;
                    cnt   <= '0;
                    state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    if (rem_ge) begin
                        rem <= rem_sh - den;
                        q   <= {q[FRAC_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= {q[FRAC_W-2:0], 1'b0};
                    end
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_FINISH: begin
                    tanh_value <= sign_r ? -q_ext : q_ext;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_activation_unit.sv
// Purpose : self-checking bench for tanh_activation_unit (directed table, corner sequences, random vs real tanh).
// Latency : expects busy high for exactly 38 cycles per accepted start.
// Backpr. : drives single-cycle start pulses; checks that pulses while busy are ignored.
module tb_tanh_activation_unit;

    logic               clk;
    logic               reset;
    logic               start;
    logic        [19:0] input_angle;
    logic               busy;
    logic signed [19:0] tanh_value;

    int n_checks = 0;
    int n_fail   = 0;

    tanh_activation_unit #(
        .DATA_W(20),
        .FRAC_W(18),
        .ITER  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .input_angle(input_angle),
        .busy       (busy),
        .tanh_value (tanh_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] angle;
        int          expv;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic check_tol(input string name, input int act, input int expv, input int tol);
        int d;
        d = act - expv;
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, expv, tol);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int expv);
        check_tol(name, act, expv, 0);
    endtask

    // Reference: tanh of the Q2.18 operand, rounded to Q2.18.
    function automatic int ref_tanh(input logic [19:0] a);
        real r;
        r = $itor($signed(a)) / 262144.0;
        return $rtoi($floor($tanh(r) * 262144.0 + 0.5));
    endfunction

    // Call at a negedge. Pulses start, counts busy cycles, checks output hold,
    // returns at the negedge where busy has fallen.
    task automatic run_op(input logic [19:0] a, output int res, output int cyc);
        logic [19:0] held;
        bit          hold_bad;
        held        = tanh_value;
        hold_bad    = 1'b0;
        input_angle = a;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        input_angle = 20'($urandom);
        cyc         = 0;
        while (busy && cyc < 60) begin
            cyc++;
            if (tanh_value !== held) hold_bad = 1'b1;
            @(negedge clk);
        end
        res = int'(tanh_value);
        n_checks++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL hold_while_busy: output changed during busy, expected %0d held", $signed(held));
        end
    endtask

    initial begin
        int          res, cyc, res_pos, res_neg;
        logic [19:0] a;

        vecs[0] = '{20'h20000, 121141, "tanh_0p5"};
        vecs[1] = '{20'h40000, 199649, "tanh_1p0"};
        vecs[2] = '{20'hC0000, -199649, "tanh_m1p0"};
        vecs[3] = '{20'h80000, -252714, "tanh_m2p0"};
        vecs[4] = '{20'h00000, 0, "tanh_zero"};
        vecs[5] = '{20'h7FFFF, 252714, "tanh_max"};

        reset       = 1'b1;
        start       = 1'b0;
        input_angle = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_value", int'(tanh_value), 0);

        // start together with reset must not launch anything
        start       = 1'b1;
        input_angle = 20'h40000;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_eq("reset_over_start_busy", int'(busy), 0);
        @(negedge clk);
        check_eq("reset_over_start_idle", int'(busy), 0);
        check_eq("reset_over_start_value", int'(tanh_value), 0);

        // directed table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].angle, res, cyc);
            check_eq({vecs[i].name, "_busy_cycles"}, cyc, 38);
            check_tol(vecs[i].name, res, vecs[i].expv, 16);
        end

        // bit-exact odd symmetry for 1.0 / -1.0
        run_op(20'h40000, res_pos, cyc);
        run_op(20'hC0000, res_neg, cyc);
        check_eq("sym_1p0", res_neg, -res_pos);

        // second start at busy cycle 10 ignored; back-to-back start accepted
        input_angle = 20'h40000;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 60) begin
            cyc++;
            if (cyc == 10) begin
                start       = 1'b1;
                input_angle = 20'h20000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("ignored_start_cycles", cyc, 38);
        check_tol("ignored_start_value", int'(tanh_value), 199649, 16);
        run_op(20'h20000, res, cyc);
        check_eq("back_to_back_cycles", cyc, 38);
        check_tol("back_to_back_value", res, 121141, 16);

        // reset at busy cycle 20 aborts without a result
        input_angle = 20'h40000;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_value", int'(tanh_value), 0);
        @(negedge clk);
        check_eq("abort_stays_idle", int'(busy), 0);
        run_op(20'h20000, res, cyc);
        check_eq("after_abort_cycles", cyc, 38);
        check_tol("after_abort_value", res, 121141, 16);

        // random operands vs real tanh, plus odd symmetry
        for (int k = 0; k < 30; k++) begin
            a = 20'($urandom_range(0, 20'hFFFFF));
            run_op(a, res_pos, cyc);
            check_eq("rand_busy_cycles", cyc, 38);
            check_tol($sformatf("rand_tanh_%05h", a), res_pos, ref_tanh(a), 16);
            if (a != 20'h80000) begin
                run_op(-a, res_neg, cyc);
                check_eq($sformatf("rand_sym_%05h", a), res_neg, -res_pos);
            end
        end

        // output holds while idle
        res = int'(tanh_value);
        input_angle = 20'h12345;
        repeat (5) @(negedge clk);
        check_eq("idle_hold", int'(tanh_value), res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
